// File: rtl/challenge_pkg.sv
// Shared types and constants for the multi-day challenge evaluator.
package challenge_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int SPEED_LO_DRY = 20;
  localparam int SPEED_LO_WET = 30;
  localparam int SPEED_HI_DRY = 50;
  localparam int SPEED_HI_WET = 70;

  localparam int BONUS_T1 = 80;
  localparam int BONUS_T2 = 87;
  localparam int BONUS_T3 = 94;

  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Galois right shift; an all-zero register stays zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] r);
    return r[0] ? ((r >> 1) ^ LFSR_MASK) : (r >> 1);
  endfunction

endpackage

// File: rtl/challenge_day_eval.sv
// One day of evaluation: commute, exam and presentation rules on the latched record.
module challenge_day_eval
  import challenge_pkg::*;
#(
  parameter int SCORE_W    = 7,
  parameter int PASS_SCORE = 70
) (
  input  logic [SCORE_W-1:0] speed,
  input  logic [SCORE_W-1:0] effort,
  input  logic [4:0]         hard,
  input  logic [1:0]         breakfast,
  input  logic [1:0]         movement,
  input  logic               weather,
  input  logic [2:0]         slide,
  input  logic [15:0]        r,
  input  logic [1:0]         carry,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         bonus,
  output logic               day_pass
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = SCORE_W'((1 << SCORE_W) - 1);

  logic [SCORE_W-1:0]        lo, hi;
  logic                      over, slow, p1, p2, accident;
  logic [3:0]                add;
  logic signed [SCORE_W+1:0] sum;
  logic                      unused_r;

  assign unused_r = ^{r[15:11], r[7:6]};

  always_comb begin
    lo   = weather ? SCORE_W'(SPEED_LO_WET) : SCORE_W'(SPEED_LO_DRY);
    hi   = weather ? SCORE_W'(SPEED_HI_WET) : SCORE_W'(SPEED_HI_DRY);
    over = speed > hi;
    slow = speed < lo;
    p1   = ~((slow & (r[2] ^ r[3])) | (over & (r[0] | r[1])) | (r[4] & r[2] & r[0]));

    add = 4'd0;
    if (hard >= 5'd16)
      add = (r[0] | r[1]) ? 4'd8 : 4'd0;
    else if (hard >= 5'd4)
      add = {1'b0, r[3], 1'b0, r[4]};

    sum = $signed((SCORE_W+2)'(effort)) + $signed((SCORE_W+2)'(add))
        + $signed((SCORE_W+2)'(carry)) - $signed((SCORE_W+2)'(hard));

    if (sum[SCORE_W+1])
      score = '0;
    else if (sum[SCORE_W])
      score = SCORE_MAX;
    else
      score = sum[SCORE_W-1:0];

    p2 = p1 & (score >= SCORE_W'(PASS_SCORE));

    if (score > SCORE_W'(BONUS_T3))      bonus = 2'd3;
    else if (score > SCORE_W'(BONUS_T2)) bonus = 2'd2;
    else if (score > SCORE_W'(BONUS_T1)) bonus = 2'd1;
    else                                 bonus = 2'd0;
    // a good breakfast with the matching warm-up guarantees the top bonus
    if (breakfast == 2'd3 && movement == {r[3], r[5]})
      bonus = 2'd3;

    accident = ((slide ^ r[10:8]) == 3'd0) && (bonus != 2'd3);
    day_pass = p2 & ~accident;
  end

endmodule

// File: rtl/challenge_pipe.sv
// Sequential challenge evaluator: accepts a record, runs DAYS LFSR-driven days, holds a verdict.
//  state | meaning
//  IDLE  | ready for a record, seed load allowed
//  RUN   | one day evaluated per clock, LFSR advancing
//  DONE  | verdict held until out_ready
module challenge_pipe
  import challenge_pkg::*;
#(
  parameter int          SCORE_W    = 7,
  parameter int          DAYS       = 4,
  parameter int          PASS_NEED  = 3,
  parameter int          PASS_SCORE = 70,
  parameter int          EARLY_EXIT = 0,
  parameter logic [15:0] SEED       = 16'hACE1,
  localparam int         CNT_W      = $clog2(DAYS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_we,
  input  logic [15:0]        seed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] speed,
  input  logic [SCORE_W-1:0] effort,
  input  logic [4:0]         hard,
  input  logic [1:0]         breakfast,
  input  logic [1:0]         movement,
  input  logic               weather,
  input  logic [2:0]         slide,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_pass,
  output logic [CNT_W-1:0]   out_pass_cnt,
  output logic [SCORE_W-1:0] out_best,
  output logic [CNT_W-1:0]   out_days
);

  state_t             state;
  logic [15:0]        lfsr;
  logic [SCORE_W-1:0] rec_speed, rec_effort;
  logic [4:0]         rec_hard;
  logic [1:0]         rec_breakfast, rec_movement;
  logic               rec_weather;
  logic [2:0]         rec_slide;
  logic [1:0]         carry;
  logic [CNT_W-1:0]   day_cnt, pass_cnt, pass_nxt;
  logic [SCORE_W-1:0] best;
  logic [SCORE_W-1:0] score;
  logic [1:0]         bonus;
  logic               day_pass, last_day;

  challenge_day_eval #(.SCORE_W(SCORE_W), .PASS_SCORE(PASS_SCORE)) u_day (
    .speed(rec_speed), .effort(rec_effort), .hard(rec_hard),
    .breakfast(rec_breakfast), .movement(rec_movement), .weather(rec_weather),
    .slide(rec_slide), .r(lfsr), .carry(carry),
    .score(score), .bonus(bonus), .day_pass(day_pass)
  );

  assign pass_nxt = (day_pass && pass_cnt != CNT_W'(DAYS)) ? pass_cnt + 1'b1 : pass_cnt;
  assign last_day = (day_cnt == CNT_W'(DAYS - 1))
                 || ((EARLY_EXIT != 0) && (pass_nxt == CNT_W'(PASS_NEED)));

  assign out_pass_cnt = pass_cnt;
  assign out_best     = best;
  assign out_days     = day_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= SEED;
      in_ready      <= 1'b1;
      out_valid     <= 1'b0;
      out_pass      <= 1'b0;
      rec_speed     <= '0;
      rec_effort    <= '0;
      rec_hard      <= '0;
      rec_breakfast <= '0;
      rec_movement  <= '0;
      rec_weather   <= 1'b0;
      rec_slide     <= '0;
      carry         <= '0;
      day_cnt       <= '0;
      pass_cnt      <= '0;
      best          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (seed_we)
            lfsr <= seed;
          if (in_valid) begin
            rec_speed     <= speed;
            rec_effort    <= effort;
            rec_hard      <= hard;
            rec_breakfast <= breakfast;
            rec_movement  <= movement;
            rec_weather   <= weather;
            rec_slide     <= slide;
            carry         <= '0;
            day_cnt       <= '0;
            pass_cnt      <= '0;
            best          <= '0;
            out_pass      <= 1'b0;
            in_ready      <= 1'b0;
            state         <= RUN;
          end
        end
        RUN: begin
          lfsr     <= lfsr_next(lfsr);
          day_cnt  <= day_cnt + 1'b1;
          pass_cnt <= pass_nxt;
          best     <= (score > best) ? score : best;
          carry    <= bonus;
          if (last_day) begin
            out_pass  <= pass_nxt >= CNT_W'(PASS_NEED);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_challenge_pipe.sv
// Scoreboard bench: two evaluators (full run and early exit) fed the same directed records.
module tb_challenge_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        seed_we = 1'b0;
  logic [15:0] seed = 16'h0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [6:0]  speed = '0, effort = '0;
  logic [4:0]  hard = '0;
  logic [1:0]  breakfast = '0, movement = '0;
  logic        weather = 1'b0;
  logic [2:0]  slide = '0;

  logic       a_in_ready, a_out_valid, a_out_pass;
  logic [2:0] a_out_pass_cnt, a_out_days;
  logic [6:0] a_out_best;
  logic       b_in_ready, b_out_valid, b_out_pass;
  logic [2:0] b_out_pass_cnt, b_out_days;
  logic [6:0] b_out_best;

  challenge_pipe u_a (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed(seed),
    .in_valid(in_valid), .in_ready(a_in_ready),
    .speed(speed), .effort(effort), .hard(hard), .breakfast(breakfast),
    .movement(movement), .weather(weather), .slide(slide),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_pass(a_out_pass),
    .out_pass_cnt(a_out_pass_cnt), .out_best(a_out_best), .out_days(a_out_days)
  );

  challenge_pipe #(.EARLY_EXIT(1)) u_b (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed(seed),
    .in_valid(in_valid), .in_ready(b_in_ready),
    .speed(speed), .effort(effort), .hard(hard), .breakfast(breakfast),
    .movement(movement), .weather(weather), .slide(slide),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_pass(b_out_pass),
    .out_pass_cnt(b_out_pass_cnt), .out_best(b_out_best), .out_days(b_out_days)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       pass;
    logic [2:0] cnt;
    logic [6:0] best;
    logic [2:0] days;
    int         acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic p, input int c, input int b, input int d);
    exp_t e;
    e.pass = p;
    e.cnt  = c[2:0];
    e.best = b[6:0];
    e.days = d[2:0];
    e.acc  = 0;
    return e;
  endfunction

  // latency counts the accept edge plus one edge per evaluated day
  task automatic vcheck(input string tag, input exp_t e, input logic p, input logic [2:0] c,
                        input logic [6:0] b, input logic [2:0] d);
    chk({tag, "_pass"}, {31'd0, p}, {31'd0, e.pass});
    chk({tag, "_pass_cnt"}, {29'd0, c}, {29'd0, e.cnt});
    chk({tag, "_best"}, {25'd0, b}, {25'd0, e.best});
    chk({tag, "_days"}, {29'd0, d}, {29'd0, e.days});
    chk({tag, "_latency"}, cyc - e.acc + 1, {29'd0, e.days} + 1);
  endtask

  bit a_seen = 1'b0;
  bit b_seen = 1'b0;

  always @(negedge clk) begin
    if (rst) a_seen = 1'b0;
    else if (a_out_valid) begin
      if (!a_seen) begin
        a_seen = 1'b1;
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_verdict: got out_valid with no record pending");
        end else vcheck("a", qa.pop_front(), a_out_pass, a_out_pass_cnt, a_out_best, a_out_days);
      end
    end else a_seen = 1'b0;
  end

  always @(negedge clk) begin
    if (rst) b_seen = 1'b0;
    else if (b_out_valid) begin
      if (!b_seen) begin
        b_seen = 1'b1;
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_verdict: got out_valid with no record pending");
        end else vcheck("b", qb.pop_front(), b_out_pass, b_out_pass_cnt, b_out_best, b_out_days);
      end
    end else b_seen = 1'b0;
  end

  task automatic set_rec(input logic w, input int sp, input int ef, input int hd,
                         input int bf, input int mv, input int sl);
    weather   = w;
    speed     = sp[6:0];
    effort    = ef[6:0];
    hard      = hd[4:0];
    breakfast = bf[1:0];
    movement  = mv[1:0];
    slide     = sl[2:0];
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (!(a_in_ready && b_in_ready)) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: in_ready low for %0d cycles", n);
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic go(input exp_t ea, input exp_t eb, input bit seed_pulse);
    bit ok;
    int n = 0;
    in_valid = 1'b1;
    wait_ready(ok);
    if (!ok) return;
    @(posedge clk); #1;
    in_valid = 1'b0;
    ea.acc = cyc;
    eb.acc = cyc;
    qa.push_back(ea);
    qb.push_back(eb);
    if (seed_pulse) begin
      seed = 16'h0000;
      seed_we = 1'b1;
      @(posedge clk); #1;
      seed_we = 1'b0;
    end
    while (!(a_out_valid && b_out_valid)) begin
      @(posedge clk); #1;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL out_valid_timeout: no verdict after %0d cycles", n);
        return;
      end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("a_in_ready_after_take", {31'd0, a_in_ready}, 32'd1);
    chk("b_in_ready_after_take", {31'd0, b_in_ready}, 32'd1);
    chk("a_out_valid_after_take", {31'd0, a_out_valid}, 32'd0);
    chk("b_out_valid_after_take", {31'd0, b_out_valid}, 32'd0);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_a_in_ready"}, {31'd0, a_in_ready}, 32'd1);
    chk({tag, "_a_out_valid"}, {31'd0, a_out_valid}, 32'd0);
    chk({tag, "_a_out_pass"}, {31'd0, a_out_pass}, 32'd0);
    chk({tag, "_a_out_pass_cnt"}, {29'd0, a_out_pass_cnt}, 32'd0);
    chk({tag, "_a_out_best"}, {25'd0, a_out_best}, 32'd0);
    chk({tag, "_a_out_days"}, {29'd0, a_out_days}, 32'd0);
    chk({tag, "_b_in_ready"}, {31'd0, b_in_ready}, 32'd1);
    chk({tag, "_b_out_valid"}, {31'd0, b_out_valid}, 32'd0);
    chk({tag, "_b_out_days"}, {29'd0, b_out_days}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // zero seed: r stays 0 for every day
    @(posedge clk); #1;
    seed = 16'h0000;
    seed_we = 1'b1;
    @(posedge clk); #1;
    seed_we = 1'b0;

    // scores 85, 86, 86, 86 all pass; early exit stops after day 3
    set_rec(1'b0, 40, 90, 5, 0, 0, 1);
    go(mk(1'b1, 4, 86, 4), mk(1'b1, 3, 86, 3), 1'b0);

    // verdict held while out_ready is low; a waiting record is ignored
    set_rec(1'b0, 40, 20, 5, 0, 0, 1);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_a_valid", {31'd0, a_out_valid}, 32'd1);
      chk("hold_a_pass", {31'd0, a_out_pass}, 32'd1);
      chk("hold_a_pass_cnt", {29'd0, a_out_pass_cnt}, 32'd4);
      chk("hold_a_best", {25'd0, a_out_best}, 32'd86);
      chk("hold_a_days", {29'd0, a_out_days}, 32'd4);
      chk("hold_a_in_ready", {31'd0, a_in_ready}, 32'd0);
      chk("hold_b_pass_cnt", {29'd0, b_out_pass_cnt}, 32'd3);
      chk("hold_b_days", {29'd0, b_out_days}, 32'd3);
      chk("hold_b_in_ready", {31'd0, b_in_ready}, 32'd0);
    end
    release_out();

    // low effort: score 15 every day, accepted one cycle after the take
    go(mk(1'b0, 0, 15, 4), mk(1'b0, 0, 15, 4), 1'b0);
    release_out();

    // slide matches r[10:8]=0: accident every day
    set_rec(1'b0, 40, 90, 5, 0, 0, 0);
    go(mk(1'b0, 0, 86, 4), mk(1'b0, 0, 86, 4), 1'b0);
    release_out();

    // breakfast bonus 3 cancels the accident; carry 3 is not cumulative (85, 88, 88, 88)
    set_rec(1'b0, 40, 90, 5, 3, 0, 0);
    go(mk(1'b1, 4, 88, 4), mk(1'b1, 3, 88, 3), 1'b0);
    release_out();

    // reset on the second RUN cycle discards the record
    set_rec(1'b0, 40, 90, 5, 0, 0, 1);
    in_valid = 1'b1;
    wait_ready(ok);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_idle_zero("midrun_reset");
    @(negedge clk);
    rst = 1'b0;

    // LFSR back at ACE1: r = ACE1, E270, 7138, 389C -> scores 70, 71, 75, 75;
    // a seed_we pulse during RUN must not disturb the sequence
    set_rec(1'b0, 40, 80, 10, 0, 0, 7);
    go(mk(1'b1, 4, 75, 4), mk(1'b1, 3, 75, 3), 1'b1);
    release_out();

    repeat (5) @(posedge clk);
    #1;
    chk("a_queue_empty", qa.size(), 32'd0);
    chk("b_queue_empty", qb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
